// File: rtl/alu_exec_if.sv
// alu_exec request/response bundle.
// The requester drives start, operation, a and b; the ALU drives everything else.
interface alu_exec_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       operation;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             eq;
  logic             lt;
  logic             ovf;
  logic             dz;
  logic             illegal;

  modport master (
    output start, operation, a, b,
    input  busy, done, result, result_hi,
    input  eq, lt, ovf, dz, illegal
  );

  modport slave (
    input  start, operation, a, b,
    output busy, done, result, result_hi,
    output eq, lt, ovf, dz, illegal
  );
endinterface

// File: rtl/alu_exec.sv
// Multi-cycle ALU: single-cycle ops, shift-add multiply, restoring divide.
// Division is built only when ALU_EXEC_DIV_EN is defined; otherwise 0100 is illegal.
module alu_exec #(
  parameter int WIDTH = 16
) (
  input logic       clk,
  input logic       rst,
  alu_exec_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_JMP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_MOV = 4'b0101;
  localparam logic [3:0] OP_SWP = 4'b0110;
  localparam logic [3:0] OP_ORA = 4'b0111;
  localparam logic [3:0] OP_CMP = 4'b1001;

`ifdef ALU_EXEC_DIV_EN
  typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, EXEC, MUL, DONE} state_t;
`endif

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             eq, lt, ovf, dz, illegal;

  logic [WIDTH-1:0] r_n, h_n, sum, dif;
  logic             eq_n, lt_n, ovf_n, dz_n, ill_n;
  logic [WIDTH:0]   msum;

  assign sum  = a_q + b_q;
  assign dif  = a_q - b_q;
  assign msum = {1'b0, hi} + {1'b0, lo[0] ? a_q : {WIDTH{1'b0}}};

`ifdef ALU_EXEC_DIV_EN
  logic [WIDTH:0] rsh, rdf;
  assign rsh = {hi, lo[WIDTH-1]};
  assign rdf = rsh - {1'b0, b_q};
`endif

  // Result formation; mult/div read their finished product or quotient from hi/lo.
  always_comb begin
    r_n   = '0;
    h_n   = '0;
    eq_n  = 1'b0;
    lt_n  = 1'b0;
    ovf_n = 1'b0;
    dz_n  = 1'b0;
    ill_n = 1'b0;
    unique case (op_q)
      OP_JMP: ;
      OP_ADD: begin
        r_n   = sum;
        ovf_n = (a_q[WIDTH-1] == b_q[WIDTH-1])
              && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        r_n   = dif;
        ovf_n = (a_q[WIDTH-1] != b_q[WIDTH-1])
              && (dif[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_MUL: begin
        r_n   = lo;
        h_n   = hi;
        ovf_n = |hi;
      end
`ifdef ALU_EXEC_DIV_EN
      OP_DIV: begin
        if (b_q == '0) begin
          r_n  = '1;
          h_n  = a_q;
          dz_n = 1'b1;
        end else begin
          r_n = lo;
          h_n = hi;
        end
      end
`endif
      OP_MOV: r_n = b_q;
      OP_SWP: begin
        r_n = b_q;
        h_n = a_q;
      end
      OP_ORA: begin
        r_n = a_q | b_q;
        h_n = a_q & b_q;
      end
      OP_CMP: begin
        eq_n = (a_q == b_q);
        lt_n = ($signed(a_q) < $signed(b_q));
      end
      default: ill_n = 1'b1;
    endcase
  end

  // Mult/div finish through EXEC so every path shares one result-forming cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      eq        <= 1'b0;
      lt        <= 1'b0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            op_q <= bus.operation;
            a_q  <= bus.a;
            b_q  <= bus.b;
            hi   <= '0;
            lo   <= (bus.operation == OP_DIV) ? bus.a : bus.b;
            cnt  <= '0;
            busy <= 1'b1;
            if (bus.operation == OP_MUL)
              state <= MUL;
`ifdef ALU_EXEC_DIV_EN
            else if (bus.operation == OP_DIV && bus.b != '0)
              state <= DIV;
`endif
            else
              state <= EXEC;
          end
        end
        MUL: begin
          hi  <= msum[WIDTH:1];
          lo  <= {msum[0], lo[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= EXEC;
        end
`ifdef ALU_EXEC_DIV_EN
        DIV: begin
          if (!rdf[WIDTH]) begin
            hi <= rdf[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], 1'b1};
          end else begin
            hi <= rsh[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= EXEC;
        end
`endif
        EXEC: begin
          result    <= r_n;
          result_hi <= h_n;
          eq        <= eq_n;
          lt        <= lt_n;
          ovf       <= ovf_n;
          dz        <= dz_n;
          illegal   <= ill_n;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.result    = result;
  assign bus.result_hi = result_hi;
  assign bus.eq        = eq;
  assign bus.lt        = lt;
  assign bus.ovf       = ovf;
  assign bus.dz        = dz;
  assign bus.illegal   = illegal;
endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec at WIDTH=16.
// Directed vector table, random ops against an arithmetic model, handshake/reset sequences.
module tb_alu_exec;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_exec_if #(.WIDTH(W)) bus();
  alu_exec #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] hi;
    logic eq, lt, ovf, dz, ill;
  } res_t;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b;
    res_t        exp;
    int          lat;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  vec_t tv[$];

`ifdef ALU_EXEC_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic res_t sample();
    return {bus.result, bus.result_hi, bus.eq, bus.lt, bus.ovf, bus.dz, bus.illegal};
  endfunction

  function automatic res_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    res_t m = '0;
    int s;
    logic [31:0] p;
    case (op)
      4'h1: begin
        m.res = a + b;
        s = int'($signed(a)) + int'($signed(b));
        m.ovf = (s > 32767) || (s < -32768);
      end
      4'h2: begin
        m.res = a - b;
        s = int'($signed(a)) - int'($signed(b));
        m.ovf = (s > 32767) || (s < -32768);
      end
      4'h3: begin
        p = 32'(a) * 32'(b);
        m.res = p[15:0];
        m.hi  = p[31:16];
        m.ovf = (p[31:16] != 0);
      end
      4'h4: begin
        if (!DIV_ON) m.ill = 1'b1;
        else if (b == 0) begin
          m.res = 16'hFFFF;
          m.hi  = a;
          m.dz  = 1'b1;
        end else begin
          m.res = a / b;
          m.hi  = a % b;
        end
      end
      4'h5: m.res = b;
      4'h6: begin m.res = b; m.hi = a; end
      4'h7: begin m.res = a | b; m.hi = a & b; end
      4'h9: begin
        m.eq = (a == b);
        m.lt = int'($signed(a)) < int'($signed(b));
      end
      4'h0: ;
      default: m.ill = 1'b1;
    endcase
    return m;
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [15:0] b);
    if (op == 4'h3) return W + 2;
    if (op == 4'h4 && DIV_ON && b != 0) return W + 2;
    return 2;
  endfunction

  function automatic vec_t mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] r, input logic [15:0] h,
                              input logic [4:0] fl, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b;
    v.exp = {r, h, fl};
    v.lat = lat;
    return v;
  endfunction

  // Accepts one op, scrambles inputs afterwards, returns outputs and start-to-done cycles.
  task automatic run(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                     output res_t got, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.operation = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.operation = 4'($urandom);
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    chk("busy_after_accept", 64'(bus.busy), 64'(1));
    lat = 1;
    while (bus.done !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    got = sample();
    chk("done_seen", 64'(bus.done), 64'(1));
    chk("busy_at_done", 64'(bus.busy), 64'(0));
    @(posedge clk); #1;
    chk("done_pulse", 64'(bus.done), 64'(0));
    chk("hold", 64'(sample()), 64'(got));
  endtask

  res_t got;
  int   lat, ndone, seen_lat;
  logic [3:0]  rop;
  logic [15:0] ra, rb;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.operation = '0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_outputs", 64'(sample()), 64'(0));
    @(negedge clk); rst = 1'b0;

    // flags = {eq, lt, ovf, dz, ill}
    tv.push_back(mk(4'h1, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 5'b00100, 2));
    tv.push_back(mk(4'h1, 16'h0003, 16'h0004, 16'h0007, 16'h0000, 5'b00000, 2));
    tv.push_back(mk(4'h2, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 5'b00100, 2));
    tv.push_back(mk(4'h2, 16'h0005, 16'h0007, 16'hFFFE, 16'h0000, 5'b00000, 2));
    tv.push_back(mk(4'h3, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 5'b00100, 18));
    tv.push_back(mk(4'h3, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 5'b00100, 18));
    tv.push_back(mk(4'h3, 16'h00FF, 16'h0100, 16'hFF00, 16'h0000, 5'b00000, 18));
    tv.push_back(mk(4'h3, 16'hABCD, 16'h0000, 16'h0000, 16'h0000, 5'b00000, 18));
    tv.push_back(mk(4'h5, 16'h1111, 16'h2222, 16'h2222, 16'h0000, 5'b00000, 2));
    tv.push_back(mk(4'h6, 16'hAAAA, 16'h5555, 16'h5555, 16'hAAAA, 5'b00000, 2));
    tv.push_back(mk(4'h7, 16'hF0F0, 16'hFF00, 16'hFFF0, 16'hF000, 5'b00000, 2));
    tv.push_back(mk(4'h9, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 5'b01000, 2));
    tv.push_back(mk(4'h9, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 5'b10000, 2));
    tv.push_back(mk(4'h9, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 5'b00000, 2));
    tv.push_back(mk(4'h0, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 5'b00000, 2));
    tv.push_back(mk(4'hF, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 5'b00001, 2));
    tv.push_back(mk(4'h8, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 5'b00001, 2));
`ifdef ALU_EXEC_DIV_EN
    tv.push_back(mk(4'h4, 16'd100, 16'd7, 16'd14, 16'd2, 5'b00000, 18));
    tv.push_back(mk(4'h4, 16'd5, 16'd0, 16'hFFFF, 16'd5, 5'b00010, 2));
    tv.push_back(mk(4'h4, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 5'b00000, 18));
`else
    tv.push_back(mk(4'h4, 16'd100, 16'd7, 16'h0000, 16'h0000, 5'b00001, 2));
    tv.push_back(mk(4'h4, 16'd5, 16'd0, 16'h0000, 16'h0000, 5'b00001, 2));
`endif

    foreach (tv[i]) begin
      run(tv[i].op, tv[i].a, tv[i].b, got, lat);
      chk($sformatf("vec%0d_op%0h_out", i, tv[i].op), 64'(got), 64'(tv[i].exp));
      chk($sformatf("vec%0d_op%0h_lat", i, tv[i].op), 64'(lat), 64'(tv[i].lat));
    end

    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rop = 4'($urandom_range(3, 4));
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      run(rop, ra, rb, got, lat);
      chk($sformatf("rnd op=%0h a=%0h b=%0h out", rop, ra, rb), 64'(got), 64'(model(rop, ra, rb)));
      chk($sformatf("rnd op=%0h a=%0h b=%0h lat", rop, ra, rb), 64'(lat), 64'(exp_lat(rop, rb)));
    end

    // Start pulse while busy must be dropped, not queued.
    @(negedge clk);
    bus.start = 1'b1; bus.operation = 4'h3; bus.a = 16'h1234; bus.b = 16'h0100;
    @(posedge clk); #1;
    bus.start = 1'b0; lat = 1;
    @(posedge clk); #1; lat = 2;
    @(negedge clk);
    bus.start = 1'b1; bus.operation = 4'h1; bus.a = 16'h7FFF; bus.b = 16'h0001;
    @(posedge clk); #1; lat = 3;
    bus.start = 1'b0;
    ndone = 0; seen_lat = 0; got = '0;
    while (lat < 40) begin
      if (bus.done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin seen_lat = lat; got = sample(); end
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("ignore_ndone", 64'(ndone), 64'(1));
    chk("ignore_lat", 64'(seen_lat), 64'(18));
    chk("ignore_out", 64'(got), 64'(model(4'h3, 16'h1234, 16'h0100)));

    // Reset on cycle 8 of a multiply aborts it.
    @(negedge clk);
    bus.start = 1'b1; bus.operation = 4'h3; bus.a = 16'hFFFF; bus.b = 16'hFFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_done", 64'(bus.done), 64'(0));
    chk("abort_outputs", 64'(sample()), 64'(0));
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'(0));

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.operation = 4'h3;
    @(posedge clk); #1;
    chk("rst_start_busy", 64'(bus.busy), 64'(0));
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    ndone = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
    end
    chk("rst_start_quiet", 64'(ndone), 64'(0));

    run(4'h1, 16'h7FFF, 16'h0001, got, lat);
    chk("recover_out", 64'(got), 64'(model(4'h1, 16'h7FFF, 16'h0001)));
    chk("recover_lat", 64'(lat), 64'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, datapath width in bits (legal 8..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, with synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request strobe, sampled only when busy=0.
REQ-005 The block SHALL have port operation, input, 4, the ALU control code, captured with start.
REQ-006 The block SHALL have ports a and b, input, WIDTH each, as operands captured with start.
REQ-007 The block SHALL have port busy, output, 1, high from the cycle after acceptance until the cycle done is asserted.
REQ-008 The block SHALL have port done, output, 1, a one-cycle pulse that marks result, result_hi and flags valid.
REQ-009 The block SHALL have ports result and result_hi, output, WIDTH each, as primary and secondary results.
REQ-010 The block SHALL have ports eq, lt, ovf, dz and illegal, output, 1 each, as status flags.

Function
REQ-011 The block SHALL implement states IDLE, EXEC, MUL, DIV and DONE; in IDLE with start=1 it SHALL capture operation, a and b, set busy and go to MUL for 0011, to DIV for 0100 when b!=0, and to EXEC otherwise.
REQ-012 In EXEC, the block SHALL compute the result in one cycle, then go to DONE; done SHALL be asserted in DONE, which returns to IDLE next cycle; single-cycle latency is start edge to done = 2 cycles.
REQ-013 For operation 0001 (add), result SHALL be a+b mod 2^WIDTH, result_hi=0, and ovf SHALL be signed two's-complement overflow.
REQ-014 For operation 0010 (sub), result SHALL be a-b mod 2^WIDTH, and ovf SHALL be signed overflow.
REQ-015 For operation 0011 (mult), the block SHALL perform unsigned shift-add over exactly WIDTH MUL cycles; {result_hi,result} SHALL be the 2*WIDTH product; ovf SHALL equal (result_hi!=0).
REQ-016 For operation 0100 (division), the block SHALL perform unsigned restoring division over exactly WIDTH DIV cycles; result SHALL be the quotient and result_hi the remainder.
REQ-017 Division by zero SHALL take the EXEC path; result SHALL be all ones, result_hi=a, and dz=1.
REQ-018 For operation 0101 (move), result SHALL be b and result_hi SHALL be 0.
REQ-019 For operation 0110 (swap), result SHALL be b and result_hi SHALL be a.
REQ-020 For operation 0111 (OR/AND), result SHALL be a|b and result_hi SHALL be a&b.
REQ-021 For operation 1001 (compare), result SHALL be 0, eq SHALL be (a==b), and lt SHALL be signed (a<b); eq and lt SHALL be 0 for all other codes.
REQ-022 For operation 0000 (jump/halt), results and flags SHALL be 0.
REQ-023 For any other code, results SHALL be 0 and illegal=1, with single-cycle latency.
REQ-024 result, result_hi and flags SHALL update only on the cycle done rises and SHALL hold until the next done.
REQ-025 start while busy=1 or while in DONE SHALL be ignored, with no queuing.
REQ-026 Operand or operation changes after acceptance SHALL have no effect on the op in flight.
REQ-027 Mult/div latency, start edge to done, SHALL be WIDTH+2 cycles.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL enter IDLE and clear busy, done, result, result_hi, eq, lt, ovf, dz, illegal and all iteration counters.
REQ-029 rst asserted mid-MUL or mid-DIV SHALL abort the operation with no done pulse; rst SHALL take priority over a simultaneous start.

Configuration
REQ-030 With macro ALU_EXEC_DIV_EN defined, the division path per REQ-016/017 SHALL be present.
REQ-031 Without ALU_EXEC_DIV_EN, the DIV state and divider logic SHALL be absent, and code 0100 SHALL behave per REQ-023 (illegal=1, results 0, 2-cycle latency).

Verification
REQ-032 The bench SHALL cover: WIDTH=16, add a=16'h7FFF b=16'h0001 -> result=16'h8000, ovf=1, done 2 cycles after start.
REQ-033 The bench SHALL cover: mult a=16'h1234 b=16'h0100 -> result=16'h3400, result_hi=16'h0012, ovf=1, done exactly 18 cycles after start.
REQ-034 The bench SHALL cover: div a=100 b=7 -> result=14, result_hi=2, done at 18 cycles; div a=5 b=0 -> result=16'hFFFF, result_hi=5, dz=1, done at 2 cycles.
REQ-035 The bench SHALL cover: swap a=16'hAAAA b=16'h5555 -> result=16'h5555, result_hi=16'hAAAA; compare a=16'hFFFF b=1 -> lt=1, eq=0.
REQ-036 The bench SHALL cover: start mult, pulse start with add on cycle 3 -> add ignored, only the mult done seen; rst on cycle 8 -> busy=0 next cycle, no done, outputs 0.
REQ-037 The bench SHALL cover: operation 4'b1111 -> illegal=1, result=0; with ALU_EXEC_DIV_EN undefined, operation 0100 -> illegal=1 at 2 cycles.
